tx_queue_sched: RTL and testbench

//  Shares the PDU transmit byte FIFO among NREQ byte producers (e.g. PDU shell echo, CPU MMIO print).

---
 rtl/tx_queue_sched_if.sv | 34 +++
 rtl/tx_queue_sched.sv | 151 +++++++++++++++
 tb/tb_tx_queue_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_queue_sched_if.sv
// Bundle between tx_queue_sched and its producers, the transmit byte FIFO and uart_tx.
// Every handshake here (req_valid/req_ready, tx_valid/tx_ready) transfers exactly on a cycle where
// valid & ready are both high at the rising edge; a source holds data stable until that cycle.
interface tx_queue_sched_if #(
  parameter int NREQ = 2,
  parameter int TO_W = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              q_enqueue;
  logic [7:0]        q_enqueue_data;
  logic              q_full;
  logic              q_dequeue;
  logic [7:0]        q_head_data;
  logic              q_empty;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [1:0]        owner;
  logic              busy;
  logic [TO_W-1:0]   to_count;

  modport slave (
    input  req_valid, req_data, req_last, q_full, q_head_data, q_empty, tx_ready,
    output req_ready, q_enqueue, q_enqueue_data, q_dequeue, tx_valid, tx_data, owner, busy, to_count
  );

  modport master (
    output req_valid, req_data, req_last, q_full, q_head_data, q_empty, tx_ready,
    input  req_ready, q_enqueue, q_enqueue_data, q_dequeue, tx_valid, tx_data, owner, busy, to_count
  );
endinterface

// File: rtl/tx_queue_sched.sv
// Round-robin message arbiter in front of the transmit FIFO, plus a one-byte registered drain stage
// from the FIFO head into uart_tx. busy mirrors the arbiter FSM state bit (GRANT).
module tx_queue_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  tx_queue_sched_if.slave bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]      r_state;
  logic [1:0]      r_owner;
  logic [1:0]      r_rr_ptr;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] r_to_count;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;

  logic            w_clear;
  logic            w_grant;
  logic            w_accept;
  logic            w_timeout;
  logic            w_load;
  logic            w_own_valid;
  logic            w_own_last;
  logic [7:0]      w_own_data;
  logic            w_any;
  logic            w_hit;
  logic [1:0]      w_pick;
  logic [2:0]      w_idx;
  logic [1:0]      w_next_rr;

  assign w_clear = rst | ~en;

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 2'(i)) begin
        w_own_valid = bus.req_valid[i];
        w_own_last  = bus.req_last[i];
        w_own_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = 2'd0;
    w_idx  = 3'd0;
    w_hit  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + 3'(k);
      if (w_idx >= 3'(NREQ)) w_idx = w_idx - 3'(NREQ);
      w_hit = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (w_idx == 3'(j)) w_hit = bus.req_valid[j];
      end
      if (w_hit && !w_any) begin
        w_any  = 1'b1;
        w_pick = w_idx[1:0];
      end
    end
  end

  assign w_next_rr = (r_owner == 2'(NREQ - 1)) ? 2'd0 : r_owner + 2'd1;
  assign w_grant   = (r_state == S_GRANT) & ~w_clear;
  assign w_accept  = w_grant & w_own_valid & ~bus.q_full;
  // The idle cycle that brings the count to TIMEOUT is the one that revokes the grant.
  assign w_timeout = w_grant & ~w_own_valid & (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_load    = ~w_clear & ~bus.q_empty & (~r_tx_valid | bus.tx_ready);

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (r_owner == 2'(i))) bus.req_ready[i] = ~bus.q_full;
    end
  end

  assign bus.q_enqueue      = w_accept;
  assign bus.q_enqueue_data = w_grant ? w_own_data : 8'h00;
  assign bus.q_dequeue      = w_load;
  assign bus.tx_valid       = r_tx_valid;
  assign bus.tx_data        = r_tx_data;
  assign bus.owner          = r_owner;
  assign bus.busy           = (r_state == S_GRANT);
  assign bus.to_count       = r_to_count;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state  <= S_IDLE;
      r_owner  <= 2'd0;
      r_rr_ptr <= 2'd0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner  <= w_pick;
            r_state  <= S_GRANT;
            r_to_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_accept) begin
            r_to_cnt <= '0;
            if (w_own_last) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next_rr;
            end
          end else if (w_timeout) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_next_rr;
            r_to_cnt <= '0;
          end else if (!w_own_valid) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Revocation count survives a soft flush; only a hard reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_count <= '0;
    end else if (w_timeout && (r_to_count != '1)) begin
      r_to_count <= r_to_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_load) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= bus.q_head_data;
    end else if (bus.tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_queue_sched.sv
// Bench for tx_queue_sched: producer drivers, an 8-deep FIFO model, a tx byte scoreboard and
// directed scenarios with hand-computed timing points.
module tb_tx_queue_sched;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [8:0] pq0[$];
  logic [8:0] pq1[$];
  logic [1:0] drv_acc;
  logic       prev_hold;
  logic [7:0] prev_data;
  logic [7:0] exp_enq_data;

  logic [7:0] fmem [8];
  logic [2:0] f_wp;
  logic [2:0] f_rp;
  logic [3:0] f_cnt;

  tx_queue_sched_if #(.NREQ(NREQ), .TO_W(TO_W)) bus ();

  tx_queue_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model (8 deep, combinational head) ----------------
  always @(posedge clk) begin
    if (rst || !en) begin
      f_wp  <= 3'd0;
      f_rp  <= 3'd0;
      f_cnt <= 4'd0;
    end else begin
      if (bus.q_enqueue) begin
        fmem[f_wp] <= bus.q_enqueue_data;
        f_wp       <= f_wp + 3'd1;
      end
      if (bus.q_dequeue) f_rp <= f_rp + 3'd1;
      f_cnt <= f_cnt + 4'(bus.q_enqueue) - 4'(bus.q_dequeue);
    end
  end

  assign bus.q_full      = (f_cnt == 4'd8);
  assign bus.q_empty     = (f_cnt == 4'd0);
  assign bus.q_head_data = fmem[f_rp];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input int p, input logic [7:0] d, input logic last);
    if (p == 0) pq0.push_back({last, d});
    else        pq1.push_back({last, d});
  endtask

  task automatic wait_drain(input int budget);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && (pq0.size() == 0) && (pq1.size() == 0) &&
             !bus.busy && !bus.tx_valid;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding after %0d cycles", exp_q.size(), budget);
    end
  endtask

  // ---------------- producer driver: inputs change 1 time unit after posedge ----------------
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      drv_acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      if (drv_acc[0] && pq0.size() > 0) void'(pq0.pop_front());
      if (drv_acc[1] && pq1.size() > 0) void'(pq1.pop_front());
      bus.req_valid[0]   = (pq0.size() > 0);
      bus.req_data[7:0]  = (pq0.size() > 0) ? pq0[0][7:0] : 8'h00;
      bus.req_last[0]    = (pq0.size() > 0) ? pq0[0][8] : 1'b0;
      bus.req_valid[1]   = (pq1.size() > 0);
      bus.req_data[15:8] = (pq1.size() > 0) ? pq1[0][7:0] : 8'h00;
      bus.req_last[1]    = (pq1.size() > 0) ? pq1[0][8] : 1'b0;
    end
  end

  // ---------------- per-cycle compare against scoreboard and protocol rules ----------------
  initial begin
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && en) begin
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_extra: got %0h expected no byte at %0t", bus.tx_data, $time);
          end else begin
            check("tx_byte", bus.tx_data, exp_q.pop_front());
          end
        end
        if (prev_hold) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
        check("q_dequeue", bus.q_dequeue, !bus.q_empty && (!bus.tx_valid || bus.tx_ready));
        check("req_ready_rule",
              ($countones(bus.req_ready) <= 1) &&
              (bus.busy || bus.req_ready == 2'b00) &&
              (!bus.q_full || bus.req_ready == 2'b00) &&
              (bus.req_ready == 2'b00 || bus.req_ready == (2'b01 << bus.owner)), 1'b1);
        check("q_enqueue", bus.q_enqueue, |(bus.req_valid & bus.req_ready));
        if (|(bus.req_valid & bus.req_ready)) begin
          exp_enq_data = bus.req_ready[0] ? bus.req_data[7:0] : bus.req_data[15:8];
          check("enq_data", bus.q_enqueue_data, exp_enq_data);
        end
      end
      prev_hold = !rst && en && bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst          = 1'b1;
    en           = 1'b1;
    bus.tx_ready = 1'b1;

    // Reset with both producers offering: nothing may move.
    send(0, 8'h10, 1'b1);
    send(1, 8'h20, 1'b1);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    repeat (4) @(negedge clk);
    check("rst_ctrl", {bus.req_ready, bus.q_enqueue, bus.q_dequeue, bus.tx_valid, bus.busy}, 0);
    check("rst_data", {bus.q_enqueue_data, bus.tx_data, bus.owner}, 0);
    check("rst_to_count", bus.to_count, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("t1_bubble", bus.busy, 1'b0);
    @(negedge clk);
    check("t1_grant0", {bus.busy, bus.owner, bus.q_enqueue, bus.q_enqueue_data}, {1'b1, 2'd0, 1'b1, 8'h10});
    @(negedge clk);
    check("t1_idle", bus.busy, 1'b0);
    @(negedge clk);
    check("t1_grant1", {bus.busy, bus.owner, bus.tx_valid, bus.tx_data}, {1'b1, 2'd1, 1'b1, 8'h10});
    wait_drain(100);

    // Single three-byte message: one bubble, then three consecutive pushes.
    @(posedge clk); #2;
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b0);
    send(0, 8'h43, 1'b1);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    @(negedge clk);
    @(negedge clk);
    check("t2_wait", {bus.busy, bus.req_valid}, {1'b0, 2'b01});
    @(negedge clk);
    check("t2_push41", {bus.busy, bus.owner, bus.q_enqueue, bus.q_enqueue_data}, {1'b1, 2'd0, 1'b1, 8'h41});
    @(negedge clk);
    check("t2_push42", {bus.q_enqueue, bus.q_enqueue_data}, {1'b1, 8'h42});
    @(negedge clk);
    check("t2_push43", {bus.q_enqueue, bus.q_enqueue_data}, {1'b1, 8'h43});
    @(negedge clk);
    check("t2_done", bus.busy, 1'b0);
    wait_drain(100);

    // Contention: r0 finished last, so the pointer sits at r1 and r1 wins first.
    @(posedge clk); #2;
    send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b1);
    send(1, 8'hB0, 1'b0); send(1, 8'hB1, 1'b1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    wait_drain(100);
    @(posedge clk); #2;
    send(0, 8'hC0, 1'b0); send(0, 8'hC1, 1'b1);
    send(1, 8'hD0, 1'b0); send(1, 8'hD1, 1'b1);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    wait_drain(100);

    // Back-pressure: 300 bytes in 10-byte messages with uart stalled until the FIFO fills.
    @(posedge clk); #2;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send(0, 8'(i + 3), (i % 10) == 9);
      exp_q.push_back(8'(i + 3));
    end
    begin
      int n;
      n = 0;
      while (!bus.q_full && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!bus.q_full) begin
        checks++;
        errors++;
        $display("FAIL t4_fill: q_full=0 expected 1 after %0d cycles", n);
      end
    end
    for (int k = 0; k < 6; k++) begin
      check("t4_stall", {bus.req_ready, bus.q_enqueue, bus.busy, bus.tx_valid, bus.tx_data},
            {2'b00, 1'b0, 1'b1, 1'b1, 8'h03});
      @(negedge clk);
    end
    @(posedge clk); #2;
    bus.tx_ready = 1'b1;
    wait_drain(1000);

    // Timeout: r1 abandons its message after one byte; r0 waits behind it.
    check("t5_to_before", bus.to_count, 0);
    @(posedge clk); #2;
    send(1, 8'h77, 1'b0);
    exp_q.push_back(8'h77);
    @(negedge clk);
    @(negedge clk);
    check("t5_bubble", bus.busy, 1'b0);
    @(negedge clk);
    check("t5_grant1", {bus.busy, bus.owner, bus.q_enqueue}, {1'b1, 2'd1, 1'b1});
    @(posedge clk); #2;
    send(0, 8'h55, 1'b1);
    exp_q.push_back(8'h55);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_idle_hold", bus.busy, 1'b1);
    end
    @(negedge clk);
    check("t5_revoked", {bus.busy, bus.to_count}, {1'b0, 8'd1});
    @(negedge clk);
    check("t5_grant0", {bus.busy, bus.owner}, {1'b1, 2'd0});
    wait_drain(100);

    // Flush mid-message for one cycle.
    @(posedge clk); #2;
    send(0, 8'h31, 1'b0); send(0, 8'h32, 1'b0);
    send(0, 8'h33, 1'b0); send(0, 8'h34, 1'b1);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    en = 1'b0;
    pq0.delete();
    exp_q.delete();
    @(posedge clk); #2;
    en = 1'b1;
    @(negedge clk);
    check("t6_flushed", {bus.tx_valid, bus.busy, bus.q_dequeue}, 0);
    check("t6_to_kept", bus.to_count, 1);
    @(posedge clk); #2;
    send(0, 8'h61, 1'b0);
    send(0, 8'h62, 1'b1);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    wait_drain(100);

    // Revocation counter saturates at all-ones.
    for (int it = 0; it < 256; it++) begin
      @(posedge clk); #2;
      send(1, 8'(it), 1'b0);
      exp_q.push_back(8'(it));
      wait_drain(40);
      if (it == 9) check("t7_to_count11", bus.to_count, 11);
    end
    check("t7_saturated", bus.to_count, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
